posit_encoder: RTL and testbench

//  Final stage of the posit arithmetic datapath: packs a decoded result into a WIDTH-bit posit.

---
 rtl/posit_encoder.sv | 134 +++++++++++++
 tb/tb_posit_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder.sv
// Posit encoder: packs sign/regime/exponent/fraction into a WIDTH-bit posit with
// round-to-nearest-even and maxpos/minpos saturation, as a 2-stage valid/ready pipeline.
module posit_encoder #(
  parameter int WIDTH = 7,
  parameter int EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_regime,
  input  logic [7:0]       in_exponent,
  input  logic [7:0]       in_mantissa,
  input  logic             in_sticky,
  input  logic             in_zero,
  input  logic             in_nar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_posit
);

  localparam int BODY_W = WIDTH - 1;
  localparam int TW     = EN + 9;
  localparam int BW     = WIDTH + EN + 8;
  localparam logic signed [7:0] K_HI = 8'(WIDTH - 2);
  localparam logic signed [7:0] K_LO = 8'(-(WIDTH - 1));

  function automatic logic [WIDTH-1:0] round_pack(
    input logic [BODY_W-1:0] body,
    input logic              guard,
    input logic              sticky,
    input logic              sat_hi,
    input logic              sat_lo,
    input logic              sign,
    input logic              zero,
    input logic              nar
  );
    logic [BODY_W-1:0] b;
    logic [WIDTH-1:0]  mag;
    logic [WIDTH-1:0]  res;
    if (sat_hi)
      b = '1;
    else if (sat_lo)
      b = BODY_W'(1);
    else if (&body)
      b = '1;
    else begin
      b = body + BODY_W'(guard & (sticky | body[0]));
      if (b == '0)
        b = BODY_W'(1);
    end
    mag = {1'b0, b};
    res = sign ? -mag : mag;
    if (nar)
      res = {1'b1, {BODY_W{1'b0}}};
    else if (zero)
      res = '0;
    return res;
  endfunction

  logic signed [7:0] k;
  logic signed [8:0] kx;
  logic [8:0]        rlen;
  logic              rbit;
  logic [15:0]       em16;
  logic [TW-1:0]     tail;
  logic [BW-1:0]     bits_c;
  logic              sat_hi_c;
  logic              sat_lo_c;

  assign k    = in_regime;
  assign kx   = {k[7], k};
  assign rbit = ~kx[8];
  assign em16 = {in_exponent, in_mantissa};
  assign tail = {kx[8], em16[EN+7:0]};

  always_comb begin
    sat_hi_c = (k >= K_HI);
    sat_lo_c = (k <= K_LO);
    rlen     = kx[8] ? 9'(-kx) : 9'(kx + 9'sd1);
    // saturated regimes are overridden later; clamp keeps the shifter in range
    if (sat_hi_c || sat_lo_c)
      rlen = 9'(WIDTH - 2);
    bits_c = (rbit ? ~({BW{1'b1}} >> rlen) : '0)
           | ({tail, {(BW-TW){1'b0}}} >> rlen);
  end

  logic              vld_p1, vld_p2;
  logic [BODY_W-1:0] body_p1;
  logic              guard_p1, sticky_p1, sat_hi_p1, sat_lo_p1;
  logic              sign_p1, zero_p1, nar_p1;
  logic [WIDTH-1:0]  posit_p2;
  logic              s1_load, s2_load;

  assign s2_load   = ~vld_p2 | out_ready;
  assign s1_load   = ~vld_p1 | s2_load;
  assign in_ready  = rst & s1_load;
  assign out_valid = vld_p2;
  assign out_posit = posit_p2;

  // stage 1: assemble regime/exponent/fraction bit-string
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      body_p1   <= bits_c[BW-1 -: BODY_W];
      guard_p1  <= bits_c[BW-WIDTH];
      sticky_p1 <= (|bits_c[BW-WIDTH-1:0]) | in_sticky;
      sat_hi_p1 <= sat_hi_c;
      sat_lo_p1 <= sat_lo_c;
      sign_p1   <= in_sign;
      zero_p1   <= in_zero;
      nar_p1    <= in_nar;
    end
  end

  // stage 2: round, saturate, apply sign
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      posit_p2 <= '0;
    end else begin
      if (s1_load)
        vld_p1 <= in_valid;
      if (s2_load) begin
        vld_p2 <= vld_p1;
        if (vld_p1)
          posit_p2 <= round_pack(body_p1, guard_p1, sticky_p1, sat_hi_p1,
                                 sat_lo_p1, sign_p1, zero_p1, nar_p1);
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder at WIDTH=7, EN=1.
module tb_posit_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sign, in_sticky, in_zero, in_nar;
  logic [7:0] in_regime, in_exponent, in_mantissa;
  logic       out_valid, out_ready;
  logic [6:0] out_posit;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       s;
    logic [7:0] k;
    logic [7:0] e;
    logic [7:0] m;
    logic       st;
    logic       z;
    logic       n;
    logic [6:0] exp;
  } vec_t;

  posit_encoder #(.WIDTH(7), .EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_regime(in_regime), .in_exponent(in_exponent),
    .in_mantissa(in_mantissa), .in_sticky(in_sticky),
    .in_zero(in_zero), .in_nar(in_nar),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic drive(input vec_t v);
    in_sign = v.s; in_regime = v.k; in_exponent = v.e; in_mantissa = v.m;
    in_sticky = v.st; in_zero = v.z; in_nar = v.n;
  endtask

  // One isolated transaction; lat counts edges from accept to out_valid.
  task automatic send_one(input vec_t v, output logic [6:0] res,
                          output logic got, output int lat);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    res = 'x;
    lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (out_valid) begin
        got = 1'b1;
        res = out_posit;
        lat = i + 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_posit !== 7'h00 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: got valid=%b posit=%h ready=%b, want 0/00/0",
                 i, out_valid, out_posit, in_ready);
      end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic run_table(input string name, input vec_t v[], input bit check_lat);
    logic [6:0] res;
    logic got;
    int lat;
    for (int i = 0; i < v.size(); i++) begin
      send_one(v[i], res, got, lat);
      total++;
      if (!got || res !== v[i].exp) begin
        bad++;
        $display("FAIL %s[%0d]: got %h (valid=%b), want %h", name, i, res, got, v[i].exp);
      end
      if (check_lat) begin
        total++;
        if (lat != 2) begin
          bad++;
          $display("FAIL %s_latency[%0d]: got %0d, want 2", name, i, lat);
        end
      end
    end
  endtask

  task automatic test_exact();
    vec_t v[];
    v = new[6];
    v[0] = '{1'b0, 8'd0,   8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h20};
    v[1] = '{1'b0, 8'd0,   8'd0, 8'h80, 1'b0, 1'b0, 1'b0, 7'h24};
    v[2] = '{1'b1, 8'd0,   8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h60};
    v[3] = '{1'b0, 8'd1,   8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h30};
    v[4] = '{1'b0, 8'hFF,  8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h10};
    v[5] = '{1'b0, 8'hFF,  8'd1, 8'h00, 1'b0, 1'b0, 1'b0, 7'h18};
    run_table("exact", v, 1'b1);
  endtask

  task automatic test_rounding();
    vec_t v[];
    v = new[3];
    v[0] = '{1'b0, 8'd0, 8'd0, 8'h10, 1'b0, 1'b0, 1'b0, 7'h20};
    v[1] = '{1'b0, 8'd0, 8'd0, 8'h30, 1'b0, 1'b0, 1'b0, 7'h22};
    v[2] = '{1'b0, 8'd0, 8'd0, 8'h10, 1'b1, 1'b0, 1'b0, 7'h21};
    run_table("round", v, 1'b0);
  endtask

  task automatic test_saturation();
    vec_t v[];
    v = new[4];
    v[0] = '{1'b0, 8'd5,  8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h3F};
    v[1] = '{1'b0, 8'hFA, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h01};
    v[2] = '{1'b1, 8'd5,  8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h41};
    v[3] = '{1'b0, 8'd4,  8'd1, 8'hFF, 1'b1, 1'b0, 1'b0, 7'h3F};
    run_table("sat", v, 1'b0);
  endtask

  task automatic test_specials();
    vec_t v[];
    v = new[3];
    v[0] = '{1'b0, 8'd2, 8'd1, 8'h55, 1'b1, 1'b1, 1'b0, 7'h00};
    v[1] = '{1'b1, 8'd2, 8'd1, 8'h55, 1'b1, 1'b1, 1'b1, 7'h40};
    v[2] = '{1'b1, 8'd0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00};
    run_table("special", v, 1'b0);
  endtask

  task automatic test_mid_reset();
    vec_t v;
    v = '{1'b0, 8'd0, 8'd0, 8'h80, 1'b0, 1'b0, 1'b0, 7'h24};
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset[%0d]: got out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[6];
    logic [6:0] q[$];
    logic [6:0] held;
    logic held_v, acc, dep;
    bit [3:0] pat;
    int sent, rcv, n;
    v[0] = '{1'b0, 8'd0,  8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h20};
    v[1] = '{1'b0, 8'd0,  8'd0, 8'h80, 1'b0, 1'b0, 1'b0, 7'h24};
    v[2] = '{1'b1, 8'd0,  8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h60};
    v[3] = '{1'b0, 8'd0,  8'd0, 8'h30, 1'b0, 1'b0, 1'b0, 7'h22};
    v[4] = '{1'b0, 8'd5,  8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h3F};
    v[5] = '{1'b0, 8'hFA, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h01};
    pat = 4'b1001;
    sent = 0; rcv = 0; n = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      if (sent < 6) begin
        drive(v[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        total++;
        if (out_valid !== 1'b1 || out_posit !== held) begin
          bad++;
          $display("FAIL stall_hold[%0d]: got valid=%b posit=%h, want 1/%h",
                   cyc, out_valid, out_posit, held);
        end
      end
      total++;
      if (in_ready !== !(n == 2 && !out_ready)) begin
        bad++;
        $display("FAIL bp_ready[%0d]: got %b, want %b", cyc, in_ready, !(n == 2 && !out_ready));
      end
      acc = in_valid && in_ready;
      dep = out_valid && out_ready;
      if (dep) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_order[%0d]: got %h, want no output", cyc, out_posit);
        end else begin
          if (out_posit !== q[0]) begin
            bad++;
            $display("FAIL bp_order[%0d]: got %h, want %h", cyc, out_posit, q[0]);
          end
          void'(q.pop_front());
        end
        rcv++;
      end
      held_v = out_valid && !out_ready;
      held = out_posit;
      if (acc) begin
        q.push_back(v[sent].exp);
        sent++;
      end
      n = n + int'(acc) - int'(dep);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rcv != 6) begin
      bad++;
      $display("FAIL bp_count: got %0d outputs, want 6", rcv);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_regime = '0; in_exponent = '0; in_mantissa = '0;
    in_sticky = 1'b0; in_zero = 1'b0; in_nar = 1'b0;
    test_reset();
    test_exact();
    test_rounding();
    test_saturation();
    test_specials();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
